// File: rtl/led_cube_pkg.sv
// Shared types and default sizes for the LED-cube playlist scheduler.
package led_cube_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ANIM_W = 4;
    localparam int DEF_LOOP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_PLAY    = 3'd3,
        S_ADVANCE = 3'd4,
        S_STOP    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [DEF_ANIM_W-1:0] anim;
        logic [DEF_LOOP_W-1:0] loops;
    } playlist_entry_t;

endpackage

// File: rtl/led_cube_playlist_scheduler_if.sv
// Control-side and player-side signals of the playlist scheduler.
interface led_cube_playlist_scheduler_if
    import led_cube_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int ANIM_W = DEF_ANIM_W,
    parameter int LOOP_W = DEF_LOOP_W
);
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_addr;
    logic [ANIM_W-1:0] cfg_anim;
    logic [LOOP_W-1:0] cfg_loops;
    logic [IDX_W:0]    cfg_len;
    logic              repeat_mode;
    logic              cmd_play;
    logic              cmd_stop;
    logic              cmd_skip;
    logic              anim_wrap;
    logic              animate_start;
    logic              animate_stop;
    logic [ANIM_W-1:0] animation_sel;
    logic [IDX_W-1:0]  cur_index;
    logic              playing;
    logic              playlist_done;

    modport master (
        output cfg_we, cfg_addr, cfg_anim, cfg_loops, cfg_len, repeat_mode,
               cmd_play, cmd_stop, cmd_skip, anim_wrap,
        input  animate_start, animate_stop, animation_sel, cur_index,
               playing, playlist_done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_anim, cfg_loops, cfg_len, repeat_mode,
               cmd_play, cmd_stop, cmd_skip, anim_wrap,
        output animate_start, animate_stop, animation_sel, cur_index,
               playing, playlist_done
    );
endinterface

// File: rtl/led_cube_playlist_regfile.sv
// Playlist storage: synchronous write, asynchronous read; cleared on reset.
module led_cube_playlist_regfile
    import led_cube_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [IDX_W-1:0] waddr,
    input  playlist_entry_t wdata,
    input  logic [IDX_W-1:0] raddr,
    output playlist_entry_t rdata
);
    playlist_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A write and a read of the same entry in one cycle returns the old value.
    assign rdata = mem[raddr];
endmodule

// File: rtl/led_cube_playlist_scheduler.sv
// Walks the playlist, pulsing the player's start/stop and counting wraps per entry.
module led_cube_playlist_scheduler
    import led_cube_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int ANIM_W = DEF_ANIM_W,
    parameter int LOOP_W = DEF_LOOP_W
) (
    input logic clk,
    input logic rst_n,
    led_cube_playlist_scheduler_if.slave bus
);
    localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];

    sched_state_t      state;
    logic [IDX_W-1:0]  index;
    logic [IDX_W:0]    len_q;
    logic [ANIM_W-1:0] cur_anim;
    logic [LOOP_W-1:0] cur_loops;
    logic [LOOP_W-1:0] loop_cnt;
    logic              start_q, stop_q, playing_q, done_q;
    logic [ANIM_W-1:0] sel_q;
    playlist_entry_t   rd_entry;
    playlist_entry_t   wr_entry;
    logic [IDX_W:0]    len_clip;
    logic              last_entry;
    logic [LOOP_W:0]   loop_next;

    assign wr_entry   = '{anim: bus.cfg_anim, loops: bus.cfg_loops};
    assign len_clip   = (bus.cfg_len > DEPTH_L) ? DEPTH_L : bus.cfg_len;
    assign last_entry = ({1'b0, index} == (len_q - 1'b1));
    assign loop_next  = {1'b0, loop_cnt} + 1'b1;

    led_cube_playlist_regfile #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.cfg_we),
        .waddr (bus.cfg_addr),
        .wdata (wr_entry),
        .raddr (index),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        sched_state_t nxt;
        if (!rst_n) begin
            state     <= S_IDLE;
            index     <= '0;
            len_q     <= '0;
            cur_anim  <= '0;
            cur_loops <= '0;
            loop_cnt  <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            sel_q     <= '0;
        end else begin
            nxt = state;
            case (state)
                S_IDLE: if (bus.cmd_play && bus.cfg_len != '0) begin
                    nxt   = S_LOAD;
                    index <= '0;
                    len_q <= len_clip;
                end
                S_LOAD: begin
                    cur_anim  <= rd_entry.anim;
                    cur_loops <= rd_entry.loops;
                    loop_cnt  <= '0;
                    if (bus.cmd_stop) nxt = S_STOP;
                    else begin
                        nxt   = S_START;
                        sel_q <= rd_entry.anim;
                    end
                end
                S_START: nxt = bus.cmd_stop ? S_STOP : S_PLAY;
                S_PLAY: begin
                    if (bus.cmd_stop) nxt = S_STOP;
                    else if (bus.cmd_skip) nxt = S_ADVANCE;
                    else if (bus.anim_wrap) begin
                        if (loop_cnt != '1) loop_cnt <= loop_next[LOOP_W-1:0];
                        if (cur_loops != '0 && loop_next == {1'b0, cur_loops}) nxt = S_ADVANCE;
                    end
                end
                // done_q was latched on entry, so the exit decision matches the pulse.
                S_ADVANCE: begin
                    if (bus.cmd_stop) nxt = S_STOP;
                    else if (done_q) begin
                        nxt   = S_IDLE;
                        index <= '0;
                    end else begin
                        nxt   = S_LOAD;
                        index <= last_entry ? '0 : index + 1'b1;
                    end
                end
                S_STOP:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
            state     <= nxt;
            start_q   <= (nxt == S_START);
            stop_q    <= (nxt == S_ADVANCE) || (nxt == S_STOP);
            playing_q <= (nxt == S_LOAD) || (nxt == S_START) || (nxt == S_PLAY) || (nxt == S_ADVANCE);
            done_q    <= (nxt == S_ADVANCE) && (state != S_ADVANCE) && last_entry && !bus.repeat_mode;
        end
    end

    assign bus.animate_start = start_q;
    assign bus.animate_stop  = stop_q;
    assign bus.animation_sel = sel_q;
    assign bus.cur_index     = index;
    assign bus.playing       = playing_q;
    assign bus.playlist_done = done_q;
endmodule

// File: tb/tb_led_cube_playlist_scheduler.sv
// Directed bench for the playlist scheduler: sequencing, repeat, skip/stop priority, reset.
module tb_led_cube_playlist_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    led_cube_playlist_scheduler_if bus ();

    led_cube_playlist_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int anim, input int loops);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr[2:0];
        bus.cfg_anim  = anim[3:0];
        bus.cfg_loops = loops[3:0];
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic wrap();
        bus.anim_wrap = 1'b1;
        tick();
        bus.anim_wrap = 1'b0;
    endtask

    task automatic play();
        bus.cmd_play = 1'b1;
        tick();
        bus.cmd_play = 1'b0;
    endtask

    task automatic stop_cmd();
        bus.cmd_stop = 1'b1;
        tick();
        bus.cmd_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_anim = 0; bus.cfg_loops = 0;
        bus.cfg_len = 0; bus.repeat_mode = 0; bus.cmd_play = 0; bus.cmd_stop = 0;
        bus.cmd_skip = 0; bus.anim_wrap = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.animate_start, bus.animate_stop, bus.animation_sel, bus.cur_index,
             bus.playing, bus.playlist_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got start=%0b stop=%0b sel=%0d idx=%0d play=%0b done=%0b required all 0",
                     bus.animate_start, bus.animate_stop, bus.animation_sel, bus.cur_index,
                     bus.playing, bus.playlist_done);
        end
    endtask

    task automatic test_basic();
        write_entry(0, 3, 2);
        write_entry(1, 1, 1);
        bus.cfg_len = 2; bus.repeat_mode = 0;
        play();
        checks++;
        if (bus.animate_start !== 1'b0 || bus.playing !== 1'b1) begin
            failures++;
            $display("FAIL basic_load got start=%0b play=%0b required start=0 play=1", bus.animate_start, bus.playing);
        end
        tick();
        checks++;
        if (bus.animate_start !== 1'b1 || bus.animation_sel !== 4'd3 || bus.cur_index !== 3'd0) begin
            failures++;
            $display("FAIL basic_start0 got start=%0b sel=%0d idx=%0d required 1/3/0", bus.animate_start, bus.animation_sel, bus.cur_index);
        end
        tick();
        wrap();
        checks++;
        if (bus.animate_stop !== 1'b0) begin
            failures++;
            $display("FAIL basic_first_wrap got stop=%0b required 0", bus.animate_stop);
        end
        wrap();
        checks++;
        if (bus.animate_stop !== 1'b1 || bus.playlist_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_adv0 got stop=%0b done=%0b required 1/0", bus.animate_stop, bus.playlist_done);
        end
        tick(); tick();
        checks++;
        if (bus.animate_start !== 1'b1 || bus.animation_sel !== 4'd1 || bus.cur_index !== 3'd1) begin
            failures++;
            $display("FAIL basic_start1 got start=%0b sel=%0d idx=%0d required 1/1/1", bus.animate_start, bus.animation_sel, bus.cur_index);
        end
        tick();
        wrap();
        checks++;
        if (bus.animate_stop !== 1'b1 || bus.playlist_done !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got stop=%0b done=%0b required 1/1", bus.animate_stop, bus.playlist_done);
        end
        tick();
        checks++;
        if (bus.playing !== 1'b0 || bus.playlist_done !== 1'b0 || bus.animate_stop !== 1'b0 ||
            bus.cur_index !== 3'd0 || bus.animation_sel !== 4'd1) begin
            failures++;
            $display("FAIL basic_idle got play=%0b done=%0b stop=%0b idx=%0d sel=%0d required 0/0/0/0/1",
                     bus.playing, bus.playlist_done, bus.animate_stop, bus.cur_index, bus.animation_sel);
        end
    endtask

    task automatic test_repeat();
        bus.repeat_mode = 1;
        play();
        tick();
        checks++;
        if (bus.cur_index !== 3'd0 || bus.animate_start !== 1'b1) begin
            failures++;
            $display("FAIL repeat_idx0 got idx=%0d start=%0b required 0/1", bus.cur_index, bus.animate_start);
        end
        tick();
        wrap(); wrap();
        tick(); tick();
        checks++;
        if (bus.cur_index !== 3'd1 || bus.animation_sel !== 4'd1) begin
            failures++;
            $display("FAIL repeat_idx1 got idx=%0d sel=%0d required 1/1", bus.cur_index, bus.animation_sel);
        end
        tick();
        wrap();
        checks++;
        if (bus.animate_stop !== 1'b1 || bus.playlist_done !== 1'b0) begin
            failures++;
            $display("FAIL repeat_nodone got stop=%0b done=%0b required 1/0", bus.animate_stop, bus.playlist_done);
        end
        tick(); tick();
        checks++;
        if (bus.cur_index !== 3'd0 || bus.animation_sel !== 4'd3 || bus.animate_start !== 1'b1) begin
            failures++;
            $display("FAIL repeat_wrap_idx got idx=%0d sel=%0d start=%0b required 0/3/1", bus.cur_index, bus.animation_sel, bus.animate_start);
        end
        tick();
        wrap();
        checks++;
        if (bus.animate_stop !== 1'b0 || bus.playing !== 1'b1) begin
            failures++;
            $display("FAIL repeat_fourth_wrap got stop=%0b play=%0b required 0/1", bus.animate_stop, bus.playing);
        end
        stop_cmd();
        checks++;
        if (bus.animate_stop !== 1'b1 || bus.playing !== 1'b0 || bus.animate_start !== 1'b0) begin
            failures++;
            $display("FAIL repeat_stop got stop=%0b play=%0b start=%0b required 1/0/0", bus.animate_stop, bus.playing, bus.animate_start);
        end
        tick();
        checks++;
        if (bus.animate_stop !== 1'b0 || bus.playing !== 1'b0) begin
            failures++;
            $display("FAIL repeat_single_stop got stop=%0b play=%0b required 0/0", bus.animate_stop, bus.playing);
        end
    endtask

    task automatic test_infinite_skip();
        int stops = 0;
        write_entry(0, 5, 0);
        bus.cfg_len = 1; bus.repeat_mode = 1;
        play();
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            bus.anim_wrap = 1'b1;
            tick();
            if (bus.animate_stop === 1'b1) stops++;
        end
        bus.anim_wrap = 1'b0;
        checks++;
        if (stops !== 0 || bus.playing !== 1'b1) begin
            failures++;
            $display("FAIL infinite_no_stop got stops=%0d play=%0b required 0/1", stops, bus.playing);
        end
        bus.cmd_skip = 1'b1;
        tick();
        bus.cmd_skip = 1'b0;
        checks++;
        if (bus.animate_stop !== 1'b1) begin
            failures++;
            $display("FAIL skip_stop got stop=%0b required 1", bus.animate_stop);
        end
        tick(); tick();
        checks++;
        if (bus.animate_start !== 1'b1 || bus.animation_sel !== 4'd5 || bus.cur_index !== 3'd0) begin
            failures++;
            $display("FAIL skip_restart got start=%0b sel=%0d idx=%0d required 1/5/0", bus.animate_start, bus.animation_sel, bus.cur_index);
        end
        tick();
    endtask

    task automatic test_priority();
        int starts = 0;
        int stops = 0;
        bus.cmd_stop = 1'b1; bus.cmd_skip = 1'b1; bus.anim_wrap = 1'b1;
        tick();
        bus.cmd_stop = 1'b0; bus.cmd_skip = 1'b0; bus.anim_wrap = 1'b0;
        checks++;
        if (bus.animate_stop !== 1'b1 || bus.playing !== 1'b0) begin
            failures++;
            $display("FAIL prio_stop got stop=%0b play=%0b required 1/0", bus.animate_stop, bus.playing);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.animate_start === 1'b1) starts++;
            if (bus.animate_stop === 1'b1) stops++;
        end
        checks++;
        if (starts !== 0 || stops !== 0) begin
            failures++;
            $display("FAIL prio_after got starts=%0d stops=%0d required 0/0", starts, stops);
        end
    endtask

    task automatic test_len0_rewrite();
        int busy = 0;
        bus.cfg_len = 0;
        play();
        for (int i = 0; i < 3; i++) begin
            if (bus.playing === 1'b1 || bus.animate_start === 1'b1) busy++;
            tick();
        end
        checks++;
        if (busy !== 0) begin
            failures++;
            $display("FAIL len0_ignored got busy_cycles=%0d required 0", busy);
        end
        write_entry(0, 2, 1);
        write_entry(1, 4, 1);
        bus.cfg_len = 2; bus.repeat_mode = 0;
        play();
        tick();
        checks++;
        if (bus.animation_sel !== 4'd2) begin
            failures++;
            $display("FAIL rewrite_sel0 got sel=%0d required 2", bus.animation_sel);
        end
        tick();
        write_entry(1, 7, 1);
        wrap();
        tick(); tick();
        checks++;
        if (bus.animate_start !== 1'b1 || bus.animation_sel !== 4'd7 || bus.cur_index !== 3'd1) begin
            failures++;
            $display("FAIL rewrite_used got start=%0b sel=%0d idx=%0d required 1/7/1", bus.animate_start, bus.animation_sel, bus.cur_index);
        end
        tick();
    endtask

    task automatic test_reset_mid_play();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({bus.animate_start, bus.animate_stop, bus.animation_sel, bus.cur_index,
             bus.playing, bus.playlist_done} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got start=%0b stop=%0b sel=%0d idx=%0d play=%0b done=%0b required all 0",
                     bus.animate_start, bus.animate_stop, bus.animation_sel, bus.cur_index,
                     bus.playing, bus.playlist_done);
        end
        bus.cfg_len = 1; bus.repeat_mode = 0;
        play();
        write_entry(0, 9, 1);
        checks++;
        if (bus.animate_start !== 1'b1 || bus.animation_sel !== 4'd0) begin
            failures++;
            $display("FAIL midreset_cleared got start=%0b sel=%0d required 1/0", bus.animate_start, bus.animation_sel);
        end
        tick();
        wrap();
        checks++;
        if (bus.animate_stop !== 1'b0 || bus.playing !== 1'b1) begin
            failures++;
            $display("FAIL midreset_loops0 got stop=%0b play=%0b required 0/1", bus.animate_stop, bus.playing);
        end
        stop_cmd();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_infinite_skip();
        test_priority();
        test_len0_rewrite();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
